// File: rtl/demux_1to4_stream_pkg.sv
// rtl/demux_1to4_stream_pkg.sv - shared constants and types for the 1-to-4 stream demux
//
// Holds the FSM state encoding, the channel count and the select width
// used by the RTL and the testbench, plus a small one-hot decode helper.
package demux_1to4_stream_pkg;

   localparam int NCH  = 4;
   localparam int SELW = 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Channel number -> one-hot channel mask.
   function automatic logic [NCH-1:0] chan_onehot(input logic [SELW-1:0] chan);
      logic [NCH-1:0] oh;
      oh       = '0;
      oh[chan] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux_chan_cnt.sv
// rtl/demux_chan_cnt.sv - per-channel delivery counter, enable-increment with silent wrap
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset, clears the count
//   en   in   increment by one this cycle
//   cnt  out  CW-bit running count, wraps from all-ones to zero
module demux_chan_cnt #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [CW-1:0] cnt
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/demux_1to4_stream.sv
// rtl/demux_1to4_stream.sv - one-entry buffered 1-to-4 stream demultiplexer with delivery counters
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_data [DW]        upstream word
//   s0, s1              destination select {s1,s0}, sampled with in_data
//   out_valid [4]       one-hot per-channel valid (bit = held destination)
//   out_ready [4]       per-channel downstream ready
//   out_data [DW]       held word, shared by all channels
//   cnt0..cnt3 [CW]     words delivered per channel, wrapping
module demux_1to4_stream
   import demux_1to4_stream_pkg::*;
#(
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW-1:0]  in_data,
   input  logic           s0,
   input  logic           s1,
   output logic [NCH-1:0] out_valid,
   input  logic [NCH-1:0] out_ready,
   output logic [DW-1:0]  out_data,
   output logic [CW-1:0]  cnt0,
   output logic [CW-1:0]  cnt1,
   output logic [CW-1:0]  cnt2,
   output logic [CW-1:0]  cnt3
);

   state_e          state_q;
   state_e          state_d;
   logic [DW-1:0]   data_q;
   logic [DW-1:0]   data_d;
   logic [SELW-1:0] dst_q;
   logic [SELW-1:0] dst_d;

   logic            full;
   logic            in_hs;
   logic            out_hs;
   logic [NCH-1:0]  cnt_en;
   logic [CW-1:0]   cnt_w [NCH];

   // Only the ready bit of the held destination matters; the other
   // out_ready bits are masked out here.
   always_comb begin
      full   = (state_q == ST_FULL);
      out_hs = full & out_ready[dst_q];
      // Combinational ready-through: a word leaving this cycle frees the
      // register for a new one in the same cycle.
      in_ready = ~full | out_hs;
      in_hs    = in_valid & in_ready;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_hs) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_hs && !in_hs) begin
               state_d = ST_EMPTY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Data and destination only move on an accepted word, so a stalled
   // word and its select stay frozen whatever s0/s1/in_data do.
   always_comb begin
      data_d = data_q;
      dst_d  = dst_q;
      if (in_hs) begin
         data_d = in_data;
         dst_d  = {s1, s0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         dst_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dst_q   <= dst_d;
      end
   end

   always_comb begin
      out_valid = '0;
      cnt_en    = '0;
      if (full) begin
         out_valid = chan_onehot(dst_q);
      end
      // One-hot enable: at most one counter advances per cycle.
      if (out_hs) begin
         cnt_en = chan_onehot(dst_q);
      end
   end

   assign out_data = data_q;

   for (genvar k = 0; k < NCH; k++) begin : g_cnt
      demux_chan_cnt #(
         .CW(CW)
      ) u_cnt (
         .clk(clk),
         .rst(rst),
         .en (cnt_en[k]),
         .cnt(cnt_w[k])
      );
   end

   assign cnt0 = cnt_w[0];
   assign cnt1 = cnt_w[1];
   assign cnt2 = cnt_w[2];
   assign cnt3 = cnt_w[3];

endmodule
